// File: rtl/trace_pkg.sv
// Shared definitions for the retirement trace buffer: FSM state encoding, capture modes
// and entry-width helper. Entry width grows by TS_W when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam logic MODE_STOP_FULL = 1'b0;
  localparam logic MODE_WRAP      = 1'b1;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  function automatic int entry_w(input int xlen, input int ts_w);
    return 2 * xlen + (TS_EN ? ts_w : 0);
  endfunction

endpackage

// File: rtl/trace_store.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the owner's pointers and count.
module trace_store #(
  parameter int W     = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures (pc, data[, ts]) per retired instruction and drains oldest-first over valid/ready.
// Optional per-entry cycle timestamp is enabled with `define TRACE_TIMESTAMP_EN.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     mode,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic                     retire_valid,
  input  logic [XLEN-1:0]          retire_pc,
  input  logic [XLEN-1:0]          retire_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(XLEN, TS_W);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t          st;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            mode_q;
  logic [XLEN-1:0] trig_q;
  logic            ovf;
  logic            full, trig_hit, we;
  logic [EW-1:0]   wr_entry, rd_entry;

  assign full     = (cnt == FULL);
  assign trig_hit = retire_valid && (retire_pc == trig_q);
  // STOP_FULL never writes into a full store; WRAP overwrites the oldest entry instead.
  assign we = (st == ST_CAPTURE && retire_valid && !(mode_q == MODE_STOP_FULL && full))
           || (st == ST_ARMED && trig_hit);

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + 1'b1;
  end

  assign wr_entry = {retire_pc, retire_data, ts_q};
  assign rd_ts    = rd_valid ? rd_entry[TS_W-1:0] : '0;
`else
  assign wr_entry = {retire_pc, retire_data};
  assign rd_ts    = '0;
`endif

  trace_store #(.W(EW), .DEPTH(DEPTH), .AW(AW)) u_store (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Head is forced to zero outside DRAIN so the outputs read 0 out of reset.
  assign rd_valid = (st == ST_DRAIN) && (cnt != '0);
  assign rd_pc    = rd_valid ? rd_entry[EW-1 -: XLEN]      : '0;
  assign rd_data  = rd_valid ? rd_entry[EW-XLEN-1 -: XLEN] : '0;
  assign state    = st;
  assign count    = cnt;
  assign overflow = ovf;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st     <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      mode_q <= MODE_STOP_FULL;
      trig_q <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (arm) begin
            mode_q <= mode;
            trig_q <= trig_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            st     <= trig_en ? ST_ARMED : ST_CAPTURE;
          end
        end
        ST_ARMED, ST_CAPTURE: begin
          if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (full) begin
              rd_ptr <= rd_ptr + 1'b1;
              ovf    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          if (stop)
            st <= ST_DRAIN;
          else if (st == ST_ARMED && trig_hit)
            st <= ST_CAPTURE;
          else if (we && mode_q == MODE_STOP_FULL && cnt == FULL - 1'b1)
            st <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cnt == '0) begin
            st <= ST_IDLE;
          end else if (rd_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            cnt    <= cnt - 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer (DEPTH=4): a behavioural model queues expected
// entries as retirements are driven; the drain loop pops and compares the DUT head.
module tb_retire_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TS_W  = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            arm, stop, mode, trig_en;
  logic [XLEN-1:0] trig_pc;
  logic            retire_valid;
  logic [XLEN-1:0] retire_pc, retire_data;
  logic            rd_valid, rd_ready;
  logic [XLEN-1:0] rd_pc, rd_data;
  logic [TS_W-1:0] rd_ts;
  logic [1:0]      state;
  logic [2:0]      count;
  logic            overflow;

  retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm          (arm),
    .stop         (stop),
    .mode         (mode),
    .trig_en      (trig_en),
    .trig_pc      (trig_pc),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_data  (retire_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_pc        (rd_pc),
    .rd_data      (rd_data),
    .rd_ts        (rd_ts),
    .state        (state),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  int              m_st;
  bit              m_mode;
  logic [XLEN-1:0] m_trig;
  bit              m_ovf;
  logic [63:0]     sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] data_of(input logic [XLEN-1:0] pc);
    return (pc * 3) ^ 32'hA5A5_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_st = 0;
    m_ovf = 0;
    sb.delete();
  endtask

  task automatic do_arm(input bit md, input bit ten, input logic [XLEN-1:0] tpc);
    arm = 1'b1; mode = md; trig_en = ten; trig_pc = tpc;
    tick();
    arm = 1'b0; mode = 1'b0; trig_en = 1'b0; trig_pc = '0;
    m_st = ten ? 1 : 2;
    m_mode = md;
    m_trig = tpc;
    m_ovf = 0;
    sb.delete();
  endtask

  task automatic do_retire(input logic [XLEN-1:0] pc);
    retire_valid = 1'b1; retire_pc = pc; retire_data = data_of(pc);
    if (m_st == 1 && pc == m_trig) m_st = 2;
    else if (m_st == 1) m_st = 1;
    if (m_st == 2) begin
      if (!(m_mode == 1'b0 && sb.size() == DEPTH)) begin
        sb.push_back({pc, data_of(pc)});
        if (sb.size() > DEPTH) begin
          void'(sb.pop_front());
          m_ovf = 1;
        end
        if (m_mode == 1'b0 && sb.size() == DEPTH) m_st = 3;
      end
    end
    tick();
    retire_valid = 1'b0; retire_pc = '0; retire_data = '0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    if (m_st == 1 || m_st == 2) m_st = 3;
  endtask

  // Drains until the model queue is empty; ts_step>0 checks timestamp spacing.
  task automatic drain(input string tag, input int ts_step);
    logic [TS_W-1:0] prev_ts;
    bit have_prev;
    logic [63:0] exp;
    have_prev = 0;
    prev_ts = '0;
    rd_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (sb.size() == 0) break;
      check({tag, "_state"}, 64'(state), 64'(3));
      check({tag, "_count"}, 64'(count), 64'(sb.size()));
      check({tag, "_rd_valid"}, 64'(rd_valid), 64'(1));
      if (rd_valid) begin
        exp = sb.pop_front();
        check({tag, "_pc"}, 64'(rd_pc), 64'(exp[63:32]));
        check({tag, "_data"}, 64'(rd_data), 64'(exp[31:0]));
`ifdef TRACE_TIMESTAMP_EN
        if (ts_step > 0 && have_prev)
          check({tag, "_ts_step"}, 64'(TS_W'(rd_ts - prev_ts)), 64'(ts_step));
`else
        check({tag, "_ts"}, 64'(rd_ts), 64'(0));
`endif
        prev_ts = rd_ts;
        have_prev = 1;
      end
      tick();
    end
    rd_ready = 1'b0;
    check({tag, "_drain_left"}, 64'(sb.size()), 64'(0));
    check({tag, "_empty_valid"}, 64'(rd_valid), 64'(0));
    tick();
    check({tag, "_idle"}, 64'(state), 64'(0));
    m_st = 0;
  endtask

  initial begin
    logic [XLEN-1:0] head_pc, head_data;
    arm = 0; stop = 0; mode = 0; trig_en = 0; trig_pc = '0;
    retire_valid = 0; retire_pc = '0; retire_data = '0; rd_ready = 0;
    reset_n = 1'b0;
    tick();
    do_reset();

    check("rst_state", 64'(state), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_pc", 64'(rd_pc), 64'(0));
    check("rst_rd_ts", 64'(rd_ts), 64'(0));

    // STOP_FULL: fifth retirement is dropped
    do_arm(1'b0, 1'b0, '0);
    check("sf_capture", 64'(state), 64'(2));
    for (int i = 0; i < 5; i++) do_retire(XLEN'(i * 4));
    check("sf_drain", 64'(state), 64'(3));
    check("sf_count", 64'(count), 64'(DEPTH));
    check("sf_ovf", 64'(overflow), 64'(m_ovf));
    drain("sf", 0);

    // WRAP: six retirements keep the newest four
    do_arm(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) do_retire(XLEN'(i * 4));
    check("wr_still_capture", 64'(state), 64'(2));
    do_stop();
    check("wr_count", 64'(count), 64'(DEPTH));
    check("wr_ovf", 64'(overflow), 64'(m_ovf));
    check("wr_ovf_set", 64'(overflow), 64'(1));
    drain("wr", 0);

    // Trigger at 0x0C
    do_arm(1'b0, 1'b1, 32'h0C);
    check("tg_armed", 64'(state), 64'(1));
    for (int i = 0; i < 6; i++) begin
      do_retire(XLEN'(i * 4));
      check("tg_state", 64'(state), 64'(m_st));
    end
    do_stop();
    check("tg_count", 64'(count), 64'(3));
    drain("tg", 0);

    // Backpressure: head held while rd_ready is low
    do_arm(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) do_retire(32'h100 + XLEN'(i * 4));
    head_pc = sb[0][63:32];
    head_data = sb[0][31:0];
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 64'(rd_valid), 64'(1));
      check("bp_pc", 64'(rd_pc), 64'(head_pc));
      check("bp_data", 64'(rd_data), 64'(head_data));
      check("bp_count", 64'(count), 64'(DEPTH));
      tick();
    end
    drain("bp", 0);

    // Reset mid-capture discards the session
    do_arm(1'b1, 1'b0, '0);
    do_retire(32'h200);
    do_retire(32'h204);
    check("mr_count_pre", 64'(count), 64'(2));
    do_reset();
    check("mr_state", 64'(state), 64'(0));
    check("mr_count", 64'(count), 64'(0));
    check("mr_ovf", 64'(overflow), 64'(0));
    check("mr_rd_valid", 64'(rd_valid), 64'(0));

    // Retirements 3 cycles apart for timestamp spacing
    do_arm(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      do_retire(32'h300 + XLEN'(i * 4));
      tick();
      tick();
    end
    do_stop();
    drain("ts", 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
